// File: rtl/dmem_ext.sv
// Data memory with valid/ready requests, sized little-endian accesses and load extension.
// Every request gets one in-order response after READ_LATENCY cycles. Faults: misaligned or out-of-range.
module dmem_ext #(
   parameter int DMEM_DEPTH      = 1024,
   parameter int DMEM_ADDR_WIDTH = 10,
   parameter int READ_LATENCY    = 1
) (
   input  logic                       i_clk,
   input  logic                       i_reset_b,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic                       i_req_write,
   input  logic [DMEM_ADDR_WIDTH+2:0] i_req_addr,
   input  logic [1:0]                 i_req_size,
   input  logic                       i_req_unsigned,
   input  logic [63:0]                i_req_wdata,
   output logic                       o_resp_valid,
   output logic [63:0]                o_resp_rdata,
   output logic                       o_resp_fault
);

   logic [63:0] r_mem [DMEM_DEPTH];

   logic                       r_pipe_valid [READ_LATENCY];
   logic [63:0]                r_pipe_rdata [READ_LATENCY];
   logic                       r_pipe_fault [READ_LATENCY];

   logic [DMEM_ADDR_WIDTH-1:0] w_index;
   logic [2:0]                 w_offset;
   logic                       w_accept;
   logic                       w_misalign;
   logic                       w_out_of_range;
   logic                       w_fault;
   logic                       w_do_write;
   logic [63:0]                w_rd_entry;
   logic [63:0]                w_rd_shift;
   logic [63:0]                w_load;
   logic [63:0]                w_stage_rdata;
   logic [7:0]                 w_lane_mask;
   logic [7:0]                 w_be;
   logic [63:0]                w_wdata_sh;

   assign o_req_ready = i_reset_b;
   assign w_accept    = i_req_valid & o_req_ready;
   assign w_index     = i_req_addr[DMEM_ADDR_WIDTH+2:3];
   assign w_offset    = i_req_addr[2:0];

   always_comb begin
      w_misalign = 1'b0;
      case (i_req_size)
         2'd0: w_misalign = 1'b0;
         2'd1: w_misalign = i_req_addr[0];
         2'd2: w_misalign = |i_req_addr[1:0];
         default: w_misalign = |i_req_addr[2:0];
      endcase
   end

   assign w_out_of_range = (32'(w_index) >= 32'(DMEM_DEPTH));
   assign w_fault        = w_misalign | w_out_of_range;

   // Out-of-range indices never touch the array, so no read past its end either.
   assign w_rd_entry = w_out_of_range ? 64'd0 : r_mem[w_index];
   assign w_rd_shift = w_rd_entry >> {w_offset, 3'b000};

   always_comb begin
      w_load = w_rd_shift;
      case (i_req_size)
         2'd0: w_load = i_req_unsigned ? {56'd0, w_rd_shift[7:0]}
                                       : {{56{w_rd_shift[7]}}, w_rd_shift[7:0]};
         2'd1: w_load = i_req_unsigned ? {48'd0, w_rd_shift[15:0]}
                                       : {{48{w_rd_shift[15]}}, w_rd_shift[15:0]};
         2'd2: w_load = i_req_unsigned ? {32'd0, w_rd_shift[31:0]}
                                       : {{32{w_rd_shift[31]}}, w_rd_shift[31:0]};
         default: w_load = w_rd_shift;
      endcase
   end

   assign w_stage_rdata = (w_accept && !i_req_write && !w_fault) ? w_load : 64'd0;

   always_comb begin
      w_lane_mask = 8'h01;
      case (i_req_size)
         2'd0: w_lane_mask = 8'h01;
         2'd1: w_lane_mask = 8'h03;
         2'd2: w_lane_mask = 8'h0F;
         default: w_lane_mask = 8'hFF;
      endcase
   end

   // Alignment is guaranteed when writing, so the shifted mask never wraps past lane 7.
   assign w_be       = w_lane_mask << w_offset;
   assign w_wdata_sh = i_req_wdata << {w_offset, 3'b000};
   assign w_do_write = w_accept & i_req_write & ~w_fault;

   always_ff @(posedge i_clk) begin
      if (w_do_write) begin
         for (int b = 0; b < 8; b++) begin
            if (w_be[b]) begin
               r_mem[w_index][8*b +: 8] <= w_wdata_sh[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_b) begin
         for (int k = 0; k < READ_LATENCY; k++) begin
            r_pipe_valid[k] <= 1'b0;
            r_pipe_rdata[k] <= 64'd0;
            r_pipe_fault[k] <= 1'b0;
         end
      end else begin
         r_pipe_valid[0] <= w_accept;
         r_pipe_rdata[0] <= w_stage_rdata;
         r_pipe_fault[0] <= w_accept & w_fault;
         for (int k = 1; k < READ_LATENCY; k++) begin
            r_pipe_valid[k] <= r_pipe_valid[k-1];
            r_pipe_rdata[k] <= r_pipe_rdata[k-1];
            r_pipe_fault[k] <= r_pipe_fault[k-1];
         end
      end
   end

   assign o_resp_valid = r_pipe_valid[READ_LATENCY-1];
   assign o_resp_rdata = r_pipe_rdata[READ_LATENCY-1];
   assign o_resp_fault = r_pipe_fault[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_ext.sv
// Scoreboard bench for dmem_ext: the driver queues expected responses, a negedge monitor
// pops and checks data, fault flag and arrival time.
module tb_dmem_ext;
   localparam int DEPTH  = 1000;
   localparam int AW     = 10;
   localparam int RL     = 3;
   localparam int PERIOD = 10;

   logic          clk = 1'b0;
   logic          reset_b;
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [AW+2:0] req_addr;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [63:0]   req_wdata;
   logic          resp_valid;
   logic [63:0]   resp_rdata;
   logic          resp_fault;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       name;
      logic [63:0] data;
      logic        fault;
      time         due;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   dmem_ext #(
      .DMEM_DEPTH(DEPTH),
      .DMEM_ADDR_WIDTH(AW),
      .READ_LATENCY(RL)
   ) dut (
      .i_clk(clk),
      .i_reset_b(reset_b),
      .i_req_valid(req_valid),
      .o_req_ready(req_ready),
      .i_req_write(req_write),
      .i_req_addr(req_addr),
      .i_req_size(req_size),
      .i_req_unsigned(req_unsigned),
      .i_req_wdata(req_wdata),
      .o_resp_valid(resp_valid),
      .o_resp_rdata(resp_rdata),
      .o_resp_fault(resp_fault)
   );

   always #(PERIOD/2) clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic issue(input string name, input logic wr, input logic [AW+2:0] addr,
                        input logic [1:0] size, input logic uns, input logic [63:0] wdata,
                        input logic [63:0] exp_d, input logic exp_f, input bit track = 1'b1);
      exp_t e;
      @(negedge clk);
      req_valid    = 1'b1;
      req_write    = wr;
      req_addr     = addr;
      req_size     = size;
      req_unsigned = uns;
      req_wdata    = wdata;
      if (track) begin
         e.name  = name;
         e.data  = exp_d;
         e.fault = exp_f;
         e.due   = $time + RL*PERIOD;
         sb_q.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         req_valid = 1'b0;
         req_write = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      while (sb_q.size() > 0 && sb_q[0].due < $time) begin
         checks++;
         errors++;
         $display("FAIL %s: no response arrived by %0t", sb_q[0].name, sb_q[0].due);
         void'(sb_q.pop_front());
      end
      if (resp_valid === 1'b1) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp: got data %h fault %b at %0t, expected none",
                     resp_rdata, resp_fault, $time);
         end else begin
            mon_e = sb_q.pop_front();
            if (resp_rdata !== mon_e.data || resp_fault !== mon_e.fault || $time != mon_e.due) begin
               errors++;
               $display("FAIL %s: got data %h fault %b t=%0t expected data %h fault %b t=%0t",
                        mon_e.name, resp_rdata, resp_fault, $time, mon_e.data, mon_e.fault, mon_e.due);
            end
         end
      end
   end

   initial begin
      int cnt;
      int budget;
      reset_b      = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = '0;
      req_size     = 2'd0;
      req_unsigned = 1'b0;
      req_wdata    = 64'd0;

      repeat (2) @(negedge clk);
      chk("rst_resp_valid", 64'(resp_valid), 64'd0);
      chk("rst_resp_rdata", resp_rdata, 64'd0);
      chk("rst_resp_fault", 64'(resp_fault), 64'd0);
      chk("rst_ready", 64'(req_ready), 64'd0);
      reset_b = 1'b1;

      // known entry 0, then a write attempted while reset is held
      issue("st_e0", 1'b1, 13'h000, 2'd3, 1'b0, 64'h0807060504030201, 64'd0, 1'b0);
      idle(5);
      reset_b   = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 13'h000;
      req_size  = 2'd3;
      req_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      repeat (3) begin
         #1;
         chk("rst_hold_ready", 64'(req_ready), 64'd0);
         chk("rst_hold_resp_valid", 64'(resp_valid), 64'd0);
         @(negedge clk);
      end
      reset_b   = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      issue("rst_keep_e0", 1'b0, 13'h000, 2'd3, 1'b0, 64'd0, 64'h0807060504030201, 1'b0);

      // byte/half/word lanes and extension
      issue("st_e1",       1'b1, 13'h008, 2'd3, 1'b0, 64'h1122334455667788, 64'd0, 1'b0);
      issue("st_b_0b",     1'b1, 13'h00B, 2'd0, 1'b0, 64'hA5A5A5A5A5A5A580, 64'd0, 1'b0);
      issue("ld_b_s",      1'b0, 13'h00B, 2'd0, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0);
      issue("ld_b_u",      1'b0, 13'h00B, 2'd0, 1'b1, 64'd0, 64'h0000_0000_0000_0080, 1'b0);
      issue("ld_d_e1",     1'b0, 13'h008, 2'd3, 1'b0, 64'd0, 64'h1122334480667788, 1'b0);
      issue("ld_h_s",      1'b0, 13'h00A, 2'd1, 1'b0, 64'd0, 64'hFFFF_FFFF_FFFF_8066, 1'b0);
      issue("ld_h_u",      1'b0, 13'h00A, 2'd1, 1'b1, 64'd0, 64'h0000_0000_0000_8066, 1'b0);
      issue("ld_w_s_neg",  1'b0, 13'h008, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_8066_7788, 1'b0);
      issue("ld_w_s_pos",  1'b0, 13'h00C, 2'd2, 1'b0, 64'd0, 64'h0000_0000_1122_3344, 1'b0);
      issue("st_h_0c",     1'b1, 13'h00C, 2'd1, 1'b0, 64'hFFFF_0000_1234_ABCD, 64'd0, 1'b0);
      issue("ld_d_e1_b",   1'b0, 13'h008, 2'd3, 1'b0, 64'd0, 64'h1122ABCD80667788, 1'b0);
      issue("ld_h_u_0e",   1'b0, 13'h00E, 2'd1, 1'b1, 64'd0, 64'h0000_0000_0000_1122, 1'b0);
      issue("ld_b_u_0f",   1'b0, 13'h00F, 2'd0, 1'b1, 64'd0, 64'h0000_0000_0000_0011, 1'b0);

      // misalignment
      issue("mis_ld_w_06", 1'b0, 13'h006, 2'd2, 1'b0, 64'd0, 64'd0, 1'b1);
      issue("mis_st_h_03", 1'b1, 13'h003, 2'd1, 1'b0, 64'h0000_0000_0000_FFFF, 64'd0, 1'b1);
      issue("mis_ld_h_01", 1'b0, 13'h001, 2'd1, 1'b0, 64'd0, 64'd0, 1'b1);
      issue("mis_ld_d_04", 1'b0, 13'h004, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
      issue("mis_ld_w_0a", 1'b0, 13'h00A, 2'd2, 1'b1, 64'd0, 64'd0, 1'b1);
      issue("mis_keep_e0", 1'b0, 13'h000, 2'd3, 1'b0, 64'd0, 64'h0807060504030201, 1'b0);
      issue("ld_b_u_03",   1'b0, 13'h003, 2'd0, 1'b1, 64'd0, 64'h0000_0000_0000_0004, 1'b0);
      issue("ld_b_s_07",   1'b0, 13'h007, 2'd0, 1'b0, 64'd0, 64'h0000_0000_0000_0008, 1'b0);

      // back-to-back pipeline ordering
      issue("st_e4", 1'b1, 13'h020, 2'd3, 1'b0, 64'h11, 64'd0, 1'b0);
      issue("st_e5", 1'b1, 13'h028, 2'd3, 1'b0, 64'h22, 64'd0, 1'b0);
      issue("st_e6", 1'b1, 13'h030, 2'd3, 1'b0, 64'h33, 64'd0, 1'b0);
      issue("st_e7", 1'b1, 13'h038, 2'd3, 1'b0, 64'h44, 64'd0, 1'b0);
      issue("pl_ld_e4", 1'b0, 13'h020, 2'd3, 1'b0, 64'd0, 64'h11, 1'b0);
      issue("pl_ld_e5", 1'b0, 13'h028, 2'd3, 1'b0, 64'd0, 64'h22, 1'b0);
      issue("pl_ld_e6", 1'b0, 13'h030, 2'd3, 1'b0, 64'd0, 64'h33, 1'b0);
      issue("pl_ld_e7", 1'b0, 13'h038, 2'd3, 1'b0, 64'd0, 64'h44, 1'b0);

      // read-after-write
      issue("raw_st",   1'b1, 13'h010, 2'd3, 1'b0, 64'hDEAD_BEEF_CAFE_F00D, 64'd0, 1'b0);
      issue("raw_ld",   1'b0, 13'h010, 2'd3, 1'b0, 64'd0, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
      issue("raw_ld_ws", 1'b0, 13'h014, 2'd2, 1'b0, 64'd0, 64'hFFFF_FFFF_DEAD_BEEF, 1'b0);
      issue("raw_ld_wu", 1'b0, 13'h014, 2'd2, 1'b1, 64'd0, 64'h0000_0000_DEAD_BEEF, 1'b0);

      // range limit at DEPTH = 1000
      issue("rng_ld_1000",  1'b0, 13'h1F40, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
      issue("rng_st_1000",  1'b1, 13'h1F40, 2'd3, 1'b0, 64'h77, 64'd0, 1'b1);
      issue("rng_st_999",   1'b1, 13'h1F38, 2'd3, 1'b0, 64'h5A, 64'd0, 1'b0);
      issue("rng_ld_999",   1'b0, 13'h1F38, 2'd3, 1'b0, 64'd0, 64'h5A, 1'b0);
      issue("rng_ld_1023",  1'b0, 13'h1FF8, 2'd3, 1'b0, 64'd0, 64'd0, 1'b1);
      issue("rng_ld_w1000", 1'b0, 13'h1F44, 2'd2, 1'b1, 64'd0, 64'd0, 1'b1);
      idle(6);

      // reset while a store and a load are in flight: neither response may appear
      issue("mf_st", 1'b1, 13'h010, 2'd3, 1'b0, 64'h0123456789ABCDEF, 64'd0, 1'b0, 1'b0);
      issue("mf_ld", 1'b0, 13'h000, 2'd3, 1'b0, 64'd0, 64'd0, 1'b0, 1'b0);
      @(negedge clk);
      reset_b   = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (resp_valid === 1'b1) cnt++;
      end
      chk("mf_rst_rdata", resp_rdata, 64'd0);
      reset_b = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (resp_valid === 1'b1) cnt++;
      end
      chk("mf_no_resp", 64'(cnt), 64'd0);
      issue("mf_keep_st", 1'b0, 13'h010, 2'd3, 1'b0, 64'd0, 64'h0123456789ABCDEF, 1'b0);
      issue("mf_ld_e0",   1'b0, 13'h000, 2'd3, 1'b0, 64'd0, 64'h0807060504030201, 1'b0);
      idle(1);

      budget = 0;
      while (sb_q.size() > 0 && budget < 20) begin
         @(negedge clk);
         budget++;
      end
      chk("drain_empty", 64'(sb_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
